r3_stage_ctrl: RTL and testbench

- Sequencing controller for one radix-3 delay-feedback stage of the radix-3^2 FFT pipeline.
- Tracks the sample index within a 3*D block.
- Drives the butterfly/feedback mux phase, the delay-line and pipeline-register enables, and the twiddle ROM address.
- Generates output valid and start-of-frame aligned to the datapath latency of the stage's complex pipeline registers.

---
 rtl/r3_pkg.sv | 29 ++
 rtl/en_shift_pipe.sv | 38 +++
 rtl/r3_stage_ctrl.sv | 110 +++++++++++
 tb/tb_r3_stage_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/r3_pkg.sv
// Shared definitions for radix-3 delay-feedback stage controllers: phase
// encodings, the phase-to-output-bin mapping and a twiddle width helper.
package r3_pkg;

    typedef enum logic [1:0] {
        PH_FILL0 = 2'd0,
        PH_FILL1 = 2'd1,
        PH_BFLY  = 2'd2
    } r3_phase_e;

    // The sample leaving the butterfly is bin 0 during the butterfly phase,
    // then bins 1 and 2 drain from feedback during the two fill phases.
    function automatic logic [1:0] out_k_of(input r3_phase_e ph);
        case (ph)
            PH_BFLY:  return 2'd0;
            PH_FILL0: return 2'd1;
            PH_FILL1: return 2'd2;
            default:  return 2'd1;
        endcase
    endfunction

    // Smallest address width able to hold the largest exponent 2*(D-1)*stride.
    function automatic int tw_aw_min(input int d, input int stride);
        int max_exp;
        max_exp = 2 * (d - 1) * stride;
        return (max_exp == 0) ? 1 : $clog2(max_exp + 1);
    endfunction

endpackage

// File: rtl/en_shift_pipe.sv
// Clock-enabled shift register of DEPTH stages; the pipe holds its contents
// whenever en is low so a stalled datapath keeps its sideband aligned.
module en_shift_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_d;

            always_comb begin
                stage_d = stage_q[gi];
                if (en) begin
                    if (gi == 0) stage_d = d;
                    else         stage_d = stage_q[(gi == 0) ? 0 : gi - 1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) stage_q[gi] <= '0;
                else        stage_q[gi] <= stage_d;
            end
        end
    endgenerate

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/r3_stage_ctrl.sv
// Sequencer for one radix-3 delay-feedback FFT stage: block index tracking,
// butterfly/feedback phase, twiddle address and latency-aligned valid/sof.
module r3_stage_ctrl
    import r3_pkg::*;
#(
    parameter int D         = 3,
    parameter int LAT       = 2,
    parameter int TW_AW     = 4,
    parameter int TW_STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             en,
    output logic [1:0]       phase,
    output logic             bf_en,
    output logic [1:0]       out_k,
    output logic [TW_AW-1:0] tw_addr,
    output logic             out_valid,
    output logic             out_sof,
    output logic             err_sync
);

    localparam int CW = $clog2(3 * D);
    localparam int SW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(3 * D - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(D - 1);

    logic [CW-1:0] cnt_q, cnt_d, cur_cnt;
    logic [SW-1:0] sub_q, sub_d, cur_sub;
    r3_phase_e     phase_q, phase_d, cur_phase;
    logic          primed_q, primed_d;
    logic          sof_in, v0, sof0;
    logic [SW:0]   tw_prod;
    logic [1:0]    pipe_tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sub_q    <= '0;
            phase_q  <= PH_FILL0;
            primed_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            phase_q  <= phase_d;
            primed_q <= primed_d;
        end
    end

    always_comb begin
        sof_in    = in_valid & in_sof;
        err_sync  = sof_in & (cnt_q != '0);
        // A frame start always makes the current sample index 0, so the
        // datapath controls below already reflect the resynchronised position.
        cur_cnt   = sof_in ? '0 : cnt_q;
        cur_sub   = sof_in ? '0 : sub_q;
        cur_phase = sof_in ? PH_FILL0 : phase_q;

        cnt_d    = cnt_q;
        sub_d    = sub_q;
        phase_d  = phase_q;
        primed_d = primed_q;
        if (in_valid) begin
            cnt_d = (cur_cnt == CNT_LAST) ? '0 : cur_cnt + CW'(1);
            if (cur_sub == SUB_LAST) begin
                sub_d   = '0;
                phase_d = (cur_phase == PH_BFLY) ? PH_FILL0
                                                 : r3_phase_e'(cur_phase + 2'd1);
            end else begin
                sub_d   = cur_sub + SW'(1);
                phase_d = cur_phase;
            end
            primed_d = (primed_q & ~err_sync) | (cur_phase == PH_BFLY);
        end

        v0   = in_valid & primed_d;
        sof0 = v0 & (cur_phase == PH_BFLY) & (cur_sub == '0);

        en    = in_valid;
        phase = cur_phase;
        bf_en = in_valid & (cur_phase == PH_BFLY);
        out_k = out_k_of(cur_phase);

        // out_k is 0, 1 or 2, so the product is just a select of 0, sub or sub<<1.
        tw_prod = '0;
        case (out_k)
            2'd1:    tw_prod = {1'b0, cur_sub};
            2'd2:    tw_prod = {cur_sub, 1'b0};
            default: tw_prod = '0;
        endcase
        tw_addr = TW_AW'(32'(tw_prod) * 32'(TW_STRIDE));

        out_valid = pipe_tail[0] & in_valid;
        out_sof   = pipe_tail[1] & in_valid;
    end

    en_shift_pipe #(
        .WIDTH(2),
        .DEPTH(LAT)
    ) u_vs_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid),
        .d     ({sof0, v0}),
        .q     (pipe_tail)
    );

endmodule

// File: tb/tb_r3_stage_ctrl.sv
// Directed bench for r3_stage_ctrl: D=3/LAT=2 main instance plus a D=1/LAT=1
// instance; every comparison is an immediate assertion against a constant.
module tb_r3_stage_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_sof;
    logic       en, bf_en, out_valid, out_sof, err_sync;
    logic [1:0] phase, out_k;
    logic [3:0] tw_addr;

    logic       in_valid1, in_sof1;
    logic       en1, bf_en1, out_valid1, out_sof1, err_sync1;
    logic [1:0] phase1, out_k1;
    logic [3:0] tw_addr1;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int vcount;

    // Per-block expectations for D=3, TW_STRIDE=1, indexed by position 0..8.
    int ph_tab [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int k_tab  [9] = '{1, 1, 1, 2, 2, 2, 0, 0, 0};
    int tw_tab [9] = '{0, 1, 2, 0, 2, 4, 0, 0, 0};

    always #5 clk = ~clk;

    r3_stage_ctrl #(.D(3), .LAT(2), .TW_AW(4), .TW_STRIDE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .en(en), .phase(phase), .bf_en(bf_en), .out_k(out_k),
        .tw_addr(tw_addr), .out_valid(out_valid), .out_sof(out_sof),
        .err_sync(err_sync)
    );

    r3_stage_ctrl #(.D(1), .LAT(1), .TW_AW(4), .TW_STRIDE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_sof(in_sof1),
        .en(en1), .phase(phase1), .bf_en(bf_en1), .out_k(out_k1),
        .tw_addr(tw_addr1), .out_valid(out_valid1), .out_sof(out_sof1),
        .err_sync(err_sync1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic s);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        #1;
    endtask

    task automatic check_sample(input string sc, input int i, input int idx,
                                input logic ov, input logic os);
        $display("%s sample %0d idx %0d: phase=%0d k=%0d tw=%0d bf=%0b ov=%0b os=%0b",
                 sc, i, idx, phase, out_k, tw_addr, bf_en, out_valid, out_sof);
        chk({sc, " phase"},     32'(phase),     32'(ph_tab[idx]));
        chk({sc, " out_k"},     32'(out_k),     32'(k_tab[idx]));
        chk({sc, " tw_addr"},   32'(tw_addr),   32'(tw_tab[idx]));
        chk({sc, " bf_en"},     32'(bf_en),     32'(idx >= 6));
        chk({sc, " en"},        32'(en),        32'd1);
        chk({sc, " err_sync"},  32'(err_sync),  32'd0);
        chk({sc, " out_valid"}, 32'(out_valid), 32'(ov));
        chk({sc, " out_sof"},   32'(out_sof),   32'(os));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        in_valid1 = 1'b0; in_sof1 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("reset: ov=%0b os=%0b err=%0b k=%0d tw=%0d", out_valid, out_sof, err_sync, out_k, tw_addr);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_sof",   32'(out_sof),   32'd0);
        chk("rst err_sync",  32'(err_sync),  32'd0);
        chk("rst bf_en",     32'(bf_en),     32'd0);
        chk("rst tw_addr",   32'(tw_addr),   32'd0);
        chk("rst out_k",     32'(out_k),     32'd1);
        chk("rst phase",     32'(phase),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous frames: first valid output 2 cycles after sample 6.
        for (int i = 0; i < 36; i++) begin
            drive(1'b1, (i % 9) == 0);
            check_sample("cont", i, i % 9, i >= 8, (i >= 8) && ((i - 8) % 9 == 0));
        end

        // Asynchronous reset in the middle of phase 1 while outputs are valid.
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0);
        chk("pre-rst out_valid", 32'(out_valid), 32'd1);
        chk("pre-rst phase",     32'(phase),     32'd1);
        #1 rst_n = 1'b0;
        #1;
        $display("async reset: ov=%0b os=%0b err=%0b", out_valid, out_sof, err_sync);
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst out_sof",   32'(out_sof),   32'd0);
        chk("arst err_sync",  32'(err_sync),  32'd0);
        chk("arst phase",     32'(phase),     32'd0);
        drive(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stalls interleaved during phase 2; output count must match continuous.
        vcount = 0;
        for (int j = 0; j < 18; j++) begin
            drive(1'b1, (j % 9) == 0);
            check_sample("stall", j, j % 9, j >= 8, (j >= 8) && ((j - 8) % 9 == 0));
            if (out_valid) vcount++;
            if (j >= 6 && j <= 8) begin
                drive(1'b0, 1'b0);
                $display("stall idle after %0d: en=%0b ov=%0b phase=%0d", j, en, out_valid, phase);
                chk("idle en",        32'(en),        32'd0);
                chk("idle out_valid", 32'(out_valid), 32'd0);
                chk("idle bf_en",     32'(bf_en),     32'd0);
                chk("idle phase",     32'(phase),     32'(ph_tab[(j + 1) % 9]));
            end
        end
        chk("stall output count", 32'(vcount), 32'd10);

        // Frame start arriving at cnt=4: resync to index 0 and re-prime.
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0);
        drive(1'b1, 1'b1);
        $display("resync: err=%0b phase=%0d k=%0d tw=%0d", err_sync, phase, out_k, tw_addr);
        chk("resync err_sync", 32'(err_sync), 32'd1);
        chk("resync phase",    32'(phase),    32'd0);
        chk("resync tw_addr",  32'(tw_addr),  32'd0);
        for (int i = 1; i < 9; i++) begin
            drive(1'b1, 1'b0);
            $display("post-resync idx %0d: err=%0b phase=%0d ov=%0b os=%0b", i, err_sync, phase, out_valid, out_sof);
            chk("post-resync err_sync", 32'(err_sync), 32'd0);
            chk("post-resync phase",    32'(phase),    32'(ph_tab[i]));
            if (i >= 2) begin
                chk("post-resync out_valid", 32'(out_valid), 32'(i == 8));
                chk("post-resync out_sof",   32'(out_sof),   32'(i == 8));
            end
        end
        drive(1'b0, 1'b0);

        // D=1, LAT=1: phase steps every sample, first output one cycle after sample 2.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid1 = 1'b1;
            in_sof1   = (i % 3) == 0;
            #1;
            $display("d1 sample %0d: phase=%0d tw=%0d ov=%0b os=%0b", i, phase1, tw_addr1, out_valid1, out_sof1);
            chk("d1 phase",     32'(phase1),     32'(i % 3));
            chk("d1 tw_addr",   32'(tw_addr1),   32'd0);
            chk("d1 bf_en",     32'(bf_en1),     32'((i % 3) == 2));
            chk("d1 err_sync",  32'(err_sync1),  32'd0);
            chk("d1 out_valid", 32'(out_valid1), 32'(i >= 3));
            chk("d1 out_sof",   32'(out_sof1),   32'((i >= 3) && (i % 3 == 0)));
        end
        @(negedge clk);
        in_valid1 = 1'b0;
        in_sof1   = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
